// File: rtl/wb_stage.sv
// Writeback stage: selects GPR write data, issues the GPR write strobe,
// holds the HI/LO register pair, keeps a one-deep history of the last
// writeback for the hazard unit, and counts committed GPR writes.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             RegWrite,
    input  logic             MemToReg,
    input  logic             shift,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic             openHiLo,
    input  logic [63:0]      divd,
    input  logic [31:0]      ALUData,
    input  logic [31:0]      memData,
    input  logic [31:0]      shiftData,
    input  logic [4:0]       rtOrRd,
    output logic             regWriteEn,
    output logic [4:0]       regWriteAddr,
    output logic [31:0]      regWriteData,
    output logic [31:0]      hi,
    output logic [31:0]      lo,
    output logic             fwdValid,
    output logic [4:0]       fwdAddr,
    output logic [31:0]      fwdData,
    output logic [CNT_W-1:0] wbCount
);

    logic             write_en_s;
    logic [31:0]      write_data_s;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic             fwd_valid_r;
    logic [4:0]       fwd_addr_r;
    logic [31:0]      fwd_data_r;
    logic [CNT_W-1:0] wb_count_r;

    // Write strobe: register 0 is hardwired, so writes to it are suppressed.
    always_comb begin
        write_en_s = 1'b0;
        if (RegWrite && enable && !rst && (rtOrRd != 5'd0)) begin
            write_en_s = 1'b1;
        end else begin
            write_en_s = 1'b0;
        end
    end

    // Write-data select; HI/LO come from the registers, never bypassed from divd.
    always_comb begin
        write_data_s = ALUData;
        if (mfhi) begin
            write_data_s = hi_r;
        end else if (mflo) begin
            write_data_s = lo_r;
        end else if (shift) begin
            write_data_s = shiftData;
        end else if (MemToReg) begin
            write_data_s = memData;
        end else begin
            write_data_s = ALUData;
        end
    end

    // HI/LO pair loads from the divider/multiplier result when opened.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (enable && openHiLo) begin
            hi_r <= divd[63:32];
            lo_r <= divd[31:0];
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // One-deep history of the last issued writeback, frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_r <= 1'b0;
            fwd_addr_r  <= 5'd0;
            fwd_data_r  <= 32'd0;
        end else if (enable) begin
            fwd_valid_r <= write_en_s;
            fwd_addr_r  <= rtOrRd;
            fwd_data_r  <= write_data_s;
        end else begin
            fwd_valid_r <= fwd_valid_r;
            fwd_addr_r  <= fwd_addr_r;
            fwd_data_r  <= fwd_data_r;
        end
    end

    // Committed-write counter; wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_count_r <= {CNT_W{1'b0}};
        end else if (write_en_s) begin
            wb_count_r <= wb_count_r + CNT_W'(1);
        end else begin
            wb_count_r <= wb_count_r;
        end
    end

    assign regWriteEn   = write_en_s;
    assign regWriteAddr = rtOrRd;
    assign regWriteData = write_data_s;
    assign hi           = hi_r;
    assign lo           = lo_r;
    assign fwdValid     = fwd_valid_r;
    assign fwdAddr      = fwd_addr_r;
    assign fwdData      = fwd_data_r;
    assign wbCount      = wb_count_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with a 4-bit writeback counter.
module tb_wb_stage;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             RegWrite;
    logic             MemToReg;
    logic             shift;
    logic             mfhi;
    logic             mflo;
    logic             openHiLo;
    logic [63:0]      divd;
    logic [31:0]      ALUData;
    logic [31:0]      memData;
    logic [31:0]      shiftData;
    logic [4:0]       rtOrRd;
    logic             regWriteEn;
    logic [4:0]       regWriteAddr;
    logic [31:0]      regWriteData;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic             fwdValid;
    logic [4:0]       fwdAddr;
    logic [31:0]      fwdData;
    logic [CNT_W-1:0] wbCount;

    int vectors;
    int miscompares;

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .shift        (shift),
        .mfhi         (mfhi),
        .mflo         (mflo),
        .openHiLo     (openHiLo),
        .divd         (divd),
        .ALUData      (ALUData),
        .memData      (memData),
        .shiftData    (shiftData),
        .rtOrRd       (rtOrRd),
        .regWriteEn   (regWriteEn),
        .regWriteAddr (regWriteAddr),
        .regWriteData (regWriteData),
        .hi           (hi),
        .lo           (lo),
        .fwdValid     (fwdValid),
        .fwdAddr      (fwdAddr),
        .fwdData      (fwdData),
        .wbCount      (wbCount)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; enable = 1'b0; RegWrite = 1'b1; MemToReg = 1'b0; shift = 1'b0;
        mfhi = 1'b0; mflo = 1'b0; openHiLo = 1'b0; divd = 64'd0;
        ALUData = 32'd0; memData = 32'd0; shiftData = 32'd0; rtOrRd = 5'd5;

        // Reset state
        tick();
        tick();
        chk("rst_hi", hi, 64'd0);
        chk("rst_lo", lo, 64'd0);
        chk("rst_fwdValid", fwdValid, 64'd0);
        chk("rst_wbCount", wbCount, 64'd0);
        enable = 1'b1;
        #1;
        chk("rst_en_blocked", regWriteEn, 64'd0);

        // Basic ALU writeback
        rst = 1'b0; RegWrite = 1'b1; rtOrRd = 5'd5; ALUData = 32'h1234;
        #1;
        chk("alu_en", regWriteEn, 64'd1);
        chk("alu_addr", regWriteAddr, 64'd5);
        chk("alu_data", regWriteData, 64'h1234);
        tick();
        chk("alu_fwdValid", fwdValid, 64'd1);
        chk("alu_fwdAddr", fwdAddr, 64'd5);
        chk("alu_fwdData", fwdData, 64'h1234);
        chk("alu_wbCount", wbCount, 64'd1);

        // HI/LO load then mflo
        RegWrite = 1'b0; openHiLo = 1'b1; divd = 64'h0000_0003_0000_0007;
        tick();
        chk("hilo_hi", hi, 64'd3);
        chk("hilo_lo", lo, 64'd7);
        chk("hilo_wbCount", wbCount, 64'd1);
        openHiLo = 1'b0; mflo = 1'b1; RegWrite = 1'b1; rtOrRd = 5'd2;
        #1;
        chk("mflo_data", regWriteData, 64'd7);
        tick();
        chk("mflo_fwdData", fwdData, 64'd7);
        chk("mflo_wbCount", wbCount, 64'd2);

        // mfhi with same-cycle HI load reads old HI
        mflo = 1'b0; mfhi = 1'b1; openHiLo = 1'b1; divd = 64'hAAAA_AAAA_BBBB_BBBB; rtOrRd = 5'd3;
        #1;
        chk("mfhi_nobypass", regWriteData, 64'd3);
        tick();
        chk("mfhi_hi_new", hi, 64'hAAAA_AAAA);
        chk("mfhi_lo_new", lo, 64'hBBBB_BBBB);
        chk("mfhi_fwdData", fwdData, 64'd3);
        chk("mfhi_wbCount", wbCount, 64'd3);

        // Write to register 0
        mfhi = 1'b0; openHiLo = 1'b0; rtOrRd = 5'd0; ALUData = 32'h55;
        #1;
        chk("r0_en", regWriteEn, 64'd0);
        tick();
        chk("r0_wbCount", wbCount, 64'd3);
        chk("r0_fwdValid", fwdValid, 64'd0);
        chk("r0_fwdData", fwdData, 64'h55);

        // Stall holds everything
        enable = 1'b0; rtOrRd = 5'd9; openHiLo = 1'b1; divd = 64'h1111_2222_3333_4444;
        #1;
        chk("stall_en", regWriteEn, 64'd0);
        tick();
        chk("stall_hi", hi, 64'hAAAA_AAAA);
        chk("stall_lo", lo, 64'hBBBB_BBBB);
        chk("stall_fwdAddr", fwdAddr, 64'd0);
        chk("stall_fwdData", fwdData, 64'h55);
        chk("stall_wbCount", wbCount, 64'd3);

        // Write-data priority
        enable = 1'b1; RegWrite = 1'b0; openHiLo = 1'b1; divd = 64'h0000_0000_0000_0030;
        tick();
        openHiLo = 1'b0; shift = 1'b1; MemToReg = 1'b1; mflo = 1'b1;
        shiftData = 32'h10; memData = 32'h20; ALUData = 32'h40;
        #1;
        chk("prio_mflo", regWriteData, 64'h30);
        mflo = 1'b0;
        #1;
        chk("prio_shift", regWriteData, 64'h10);
        shift = 1'b0;
        #1;
        chk("prio_mem", regWriteData, 64'h20);
        MemToReg = 1'b0;
        #1;
        chk("prio_alu", regWriteData, 64'h40);

        // Counter wrap: from 3, 12 writes reach 15, 13th wraps to 0
        RegWrite = 1'b1; rtOrRd = 5'd1;
        for (int i = 0; i < 12; i++) tick();
        chk("cnt_max", wbCount, 64'hF);
        tick();
        chk("cnt_wrap", wbCount, 64'd0);
        openHiLo = 1'b1; divd = 64'h0000_0011_0000_0022;
        tick();
        chk("pre_rst_hi", hi, 64'h11);
        chk("pre_rst_wbCount", wbCount, 64'd1);

        // Reset mid-stall with RegWrite high
        openHiLo = 1'b0; enable = 1'b0; rst = 1'b1;
        #1;
        chk("rst2_en", regWriteEn, 64'd0);
        tick();
        chk("rst2_hi", hi, 64'd0);
        chk("rst2_lo", lo, 64'd0);
        chk("rst2_fwdValid", fwdValid, 64'd0);
        chk("rst2_fwdAddr", fwdAddr, 64'd0);
        chk("rst2_fwdData", fwdData, 64'd0);
        chk("rst2_wbCount", wbCount, 64'd0);

        // First enabled edge after reset updates normally
        rst = 1'b0; enable = 1'b1; rtOrRd = 5'd7; ALUData = 32'h77;
        #1;
        chk("post_rst_en", regWriteEn, 64'd1);
        tick();
        chk("post_rst_wbCount", wbCount, 64'd1);
        chk("post_rst_fwdAddr", fwdAddr, 64'd7);
        chk("post_rst_fwdData", fwdData, 64'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
